fetch_align_buffer: RTL and testbench

Instruction-fetch front end between the ICache and the Decoder. Keeps a two-line (2×64 B) window of instruction bytes around the current fetch RIP and requests lines from the ICache on an enable/done handshake. Presents a 15-byte, RIP-aligned window to the Decoder and advances by the byte count the Decoder reports consumed. Flushes and refetches on a branch/syscall redirect from EXE/WB.

---
 rtl/fetch_align_buffer.sv | 158 +++++++++++++++
 tb/tb_fetch_align_buffer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// Fetch window: two ICache lines around rip, 15-byte aligned view for the Decoder.
// Window valid the cycle after a fill; one line request in flight, held until done.
module fetch_align_buffer #(
  parameter int LINE_BYTES = 64,
  parameter int WIN_BYTES  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_rip,
  input  logic [63:0]               new_rip,
  output logic                      icache_enable,
  output logic [63:0]               icache_addr,
  input  logic [8*LINE_BYTES-1:0]   icache_rdata,
  input  logic                      icache_done,
  output logic [0:8*WIN_BYTES-1]    decode_bytes,
  output logic [63:0]               decode_rip,
  output logic                      out_valid,
  input  logic                      out_taken,
  input  logic [7:0]                bytes_consumed
);

  localparam int OFFW = $clog2(LINE_BYTES);
  localparam int LW   = 8 * LINE_BYTES;
  localparam int AW   = OFFW + 9;
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [63:0]   rip_q, rip_d;
  logic [63:0]   base_q, base_d;
  logic [63:0]   addr_q, addr_d;
  logic [LW-1:0] slot0_q, slot0_d;
  logic [LW-1:0] slot1_q, slot1_d;
  logic          v0_q, v0_d;
  logic          v1_q, v1_d;
  logic          started_q, started_d;
  logic [1:0]    fsm_q, fsm_d;

  logic [OFFW-1:0]          off;
  logic [OFFW:0]            off_end;
  logic [AW-1:0]            adv;
  logic                     consume;
  logic                     shift_line;
  logic [8*WIN_BYTES-1:0]   win;

  assign off     = OFFW'(rip_q - base_q);
  assign off_end = {1'b0, off} + (OFFW+1)'(WIN_BYTES);
  assign adv     = AW'(off) + AW'(bytes_consumed);

  assign out_valid  = started_q & v0_q & ((off_end <= (OFFW+1)'(LINE_BYTES)) | v1_q);
  assign consume    = out_valid & out_taken & ~set_rip;
  assign shift_line = adv >= AW'(LINE_BYTES);

  // Bytes beyond the end of slot0 fall through into slot1.
  assign win = (8*WIN_BYTES)'({slot1_q, slot0_q} >> {off, 3'b000});

  always_comb begin
    decode_bytes = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      decode_bytes[8*i +: 8] = win[8*i +: 8];
    end
  end

  assign decode_rip    = rip_q;
  assign icache_addr   = addr_q;
  assign icache_enable = (fsm_q != ST_IDLE);

  always_comb begin
    rip_d     = rip_q;
    base_d    = base_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    started_d = started_q;
    if (set_rip) begin
      rip_d     = new_rip;
      base_d    = new_rip & LINE_MASK;
      v0_d      = 1'b0;
      v1_d      = 1'b0;
      started_d = 1'b1;
    end else begin
      if (consume) begin
        rip_d = rip_q + 64'(bytes_consumed);
        if (shift_line) begin
          base_d  = base_q + 64'(LINE_BYTES);
          slot0_d = slot1_q;
          v0_d    = v1_q;
          v1_d    = 1'b0;
        end
      end
      // Steer the fill against the post-shift base so a line that just became slot0 lands there.
      if (fsm_q == ST_BUSY && icache_done) begin
        if (addr_q == base_d) begin
          slot0_d = icache_rdata;
          v0_d    = 1'b1;
        end else begin
          slot1_d = icache_rdata;
          v1_d    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    addr_d = addr_q;
    case (fsm_q)
      ST_IDLE: begin
        if (set_rip) begin
          fsm_d  = ST_BUSY;
          addr_d = new_rip & LINE_MASK;
        end else if (started_q && !v0_q) begin
          fsm_d  = ST_BUSY;
          addr_d = base_q;
        end else if (started_q && !v1_q) begin
          fsm_d  = ST_BUSY;
          addr_d = base_q + 64'(LINE_BYTES);
        end
      end
      ST_BUSY: begin
        if (icache_done)  fsm_d = ST_IDLE;
        else if (set_rip) fsm_d = ST_DROP;
      end
      ST_DROP: begin
        if (icache_done) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rip_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      started_q <= 1'b0;
      fsm_q     <= ST_IDLE;
    end else begin
      rip_q     <= rip_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      started_q <= started_d;
      fsm_q     <= fsm_d;
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: directed scenarios plus randomized run against a byte-memory model.
module tb_fetch_align_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         set_rip;
  logic [63:0]  new_rip;
  logic         icache_enable;
  logic [63:0]  icache_addr;
  logic [511:0] icache_rdata;
  logic         icache_done;
  logic [0:119] decode_bytes;
  logic [63:0]  decode_rip;
  logic         out_valid;
  logic         out_taken;
  logic [7:0]   bytes_consumed;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit auto_resp = 0;
  int wcnt = 0;
  int lat = 0;

  always #5 clk = ~clk;

  fetch_align_buffer dut (
    .clk(clk), .reset(reset), .set_rip(set_rip), .new_rip(new_rip),
    .icache_enable(icache_enable), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_done(icache_done),
    .decode_bytes(decode_bytes), .decode_rip(decode_rip),
    .out_valid(out_valid), .out_taken(out_taken), .bytes_consumed(bytes_consumed)
  );

  // Memory image: identity within 0x1000..0x1FFF, distinct elsewhere so stale lines are visible.
  function automatic logic [7:0] memb(input logic [63:0] a);
    logic [7:0] hi;
    logic [7:0] up;
    hi = a[19:12] - 8'd1;
    up = a[27:20];
    return a[7:0] + 8'd37 * hi + 8'd11 * up;
  endfunction

  function automatic logic [511:0] line(input logic [63:0] a);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = memb({a[63:6], 6'(k)});
    return r;
  endfunction

  function automatic logic [7:0] dbyte(input int i);
    return decode_bytes[8*i +: 8];
  endfunction

  task automatic step();
    @(negedge clk);
    if (icache_done) begin
      icache_done = 1'b0;
    end else if (auto_resp && icache_enable && !reset) begin
      if (wcnt >= lat) begin
        icache_done  = 1'b1;
        icache_rdata = line(icache_addr);
        done_cnt++;
        wcnt = 0;
        lat  = $urandom_range(0, 3);
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic give_done();
    icache_done  = 1'b1;
    icache_rdata = line(icache_addr);
  endtask

  task automatic do_reset();
    reset = 1'b1; set_rip = 1'b0; new_rip = '0; out_taken = 1'b0;
    bytes_consumed = '0; icache_done = 1'b0; icache_rdata = '0;
    auto_resp = 0; wcnt = 0; done_cnt = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    reset = 1'b1; set_rip = 1'b0; new_rip = '0; out_taken = 1'b0;
    bytes_consumed = '0; icache_done = 1'b0; icache_rdata = '0;
    step();
    checks++;
    if (out_valid !== 1'b0 || icache_enable !== 1'b0 || decode_rip !== 64'd0 ||
        icache_addr !== 64'd0 || decode_bytes !== 120'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b en=%b rip=%h addr=%h bytes=%h, need all zero",
               out_valid, icache_enable, decode_rip, icache_addr, decode_bytes);
    end
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (icache_enable !== 1'b0 || out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_request: activity seen before set_rip, need none");
    end
  endtask

  task automatic test_cold_start();
    do_reset();
    set_rip = 1'b1; new_rip = 64'h1000;
    step();
    set_rip = 1'b0;
    checks++;
    if (icache_enable !== 1'b1 || icache_addr !== 64'h1000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL cold_request: en=%b addr=%h valid=%b, need 1 1000 0",
               icache_enable, icache_addr, out_valid);
    end
    give_done();
    step();
    checks++;
    if (out_valid !== 1'b1 || decode_rip !== 64'h1000) begin
      errors++;
      $display("FAIL cold_valid: valid=%b rip=%h, need 1 1000", out_valid, decode_rip);
    end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (dbyte(i) !== 8'(i)) begin
        errors++;
        $display("FAIL cold_byte%0d: got %h need %h", i, dbyte(i), 8'(i));
      end
    end
  endtask

  task automatic test_line_straddle();
    bit bad;
    do_reset();
    set_rip = 1'b1; new_rip = 64'h1038;
    step();
    set_rip = 1'b0;
    checks++;
    if (icache_addr !== 64'h1000 || icache_enable !== 1'b1) begin
      errors++;
      $display("FAIL straddle_req0: en=%b addr=%h need 1 1000", icache_enable, icache_addr);
    end
    give_done();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL straddle_early_valid: valid=%b need 0", out_valid);
    end
    step();
    checks++;
    if (icache_enable !== 1'b1 || icache_addr !== 64'h1040 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL straddle_req1: en=%b addr=%h valid=%b need 1 1040 0",
               icache_enable, icache_addr, out_valid);
    end
    give_done();
    step();
    bad = 0;
    for (int i = 0; i < 15; i++) if (dbyte(i) !== memb(64'h1038 + 64'(i))) bad = 1;
    checks++;
    if (out_valid !== 1'b1 || bad) begin
      errors++;
      $display("FAIL straddle_window: valid=%b bytes=%h", out_valid, decode_bytes);
    end
  endtask

  task automatic test_streaming();
    logic [63:0] exp;
    bit got;
    do_reset();
    auto_resp = 1; lat = 0; wcnt = 0; done_cnt = 0;
    set_rip = 1'b1; new_rip = 64'h1000;
    step();
    set_rip = 1'b0;
    for (int n = 0; n < 40 && done_cnt < 2; n++) step();
    auto_resp = 0;
    step(); step();
    checks++;
    if (done_cnt != 2 || icache_enable !== 1'b0) begin
      errors++;
      $display("FAIL stream_fill: fills=%0d en=%b need 2 0", done_cnt, icache_enable);
    end
    exp = 64'h1000;
    for (int k = 0; k < 13; k++) begin
      checks++;
      if (decode_rip !== exp || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_step%0d: rip=%h valid=%b need %h 1", k, decode_rip, out_valid, exp);
      end
      out_taken = 1'b1; bytes_consumed = 8'd5;
      step();
      exp = exp + 64'd5;
    end
    out_taken = 1'b0; bytes_consumed = 8'd0;
    checks++;
    if (decode_rip !== 64'h1041 || out_valid !== 1'b1 || dbyte(0) !== memb(64'h1041)) begin
      errors++;
      $display("FAIL stream_cross: rip=%h valid=%b b0=%h need 1041 1 %h",
               decode_rip, out_valid, dbyte(0), memb(64'h1041));
    end
    got = 0;
    for (int n = 0; n < 4; n++) begin
      if (icache_enable === 1'b1) begin got = 1; break; end
      step();
    end
    checks++;
    if (!got || icache_addr !== 64'h1080) begin
      errors++;
      $display("FAIL stream_refill: seen=%0d addr=%h need 1 1080", got, icache_addr);
    end
  endtask

  task automatic test_redirect_busy();
    bit bad;
    do_reset();
    set_rip = 1'b1; new_rip = 64'h1000;
    step();
    set_rip = 1'b0;
    give_done();
    step();
    step();
    checks++;
    if (icache_enable !== 1'b1 || icache_addr !== 64'h1040) begin
      errors++;
      $display("FAIL busy_setup: en=%b addr=%h need 1 1040", icache_enable, icache_addr);
    end
    set_rip = 1'b1; new_rip = 64'h2000;
    step();
    set_rip = 1'b0;
    checks++;
    if (icache_enable !== 1'b1 || icache_addr !== 64'h1040 || out_valid !== 1'b0 ||
        decode_rip !== 64'h2000) begin
      errors++;
      $display("FAIL drop_hold: en=%b addr=%h valid=%b rip=%h need 1 1040 0 2000",
               icache_enable, icache_addr, out_valid, decode_rip);
    end
    give_done();
    step();
    checks++;
    if (icache_enable !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_discard: en=%b valid=%b need 0 0", icache_enable, out_valid);
    end
    step();
    checks++;
    if (icache_enable !== 1'b1 || icache_addr !== 64'h2000 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_refetch: en=%b addr=%h valid=%b need 1 2000 0",
               icache_enable, icache_addr, out_valid);
    end
    give_done();
    step();
    bad = 0;
    for (int i = 0; i < 15; i++) if (dbyte(i) !== memb(64'h2000 + 64'(i))) bad = 1;
    checks++;
    if (out_valid !== 1'b1 || bad) begin
      errors++;
      $display("FAIL drop_window: valid=%b bytes=%h", out_valid, decode_bytes);
    end
  endtask

  task automatic test_redirect_and_consume();
    // Continues from the redirect-during-busy state: window valid at 0x2000.
    set_rip = 1'b1; new_rip = 64'h3004; out_taken = 1'b1; bytes_consumed = 8'd3;
    step();
    set_rip = 1'b0; out_taken = 1'b0; bytes_consumed = 8'd0;
    checks++;
    if (decode_rip !== 64'h3004 || out_valid !== 1'b0 ||
        icache_enable !== 1'b1 || icache_addr !== 64'h3000) begin
      errors++;
      $display("FAIL redirect_consume: rip=%h valid=%b en=%b addr=%h need 3004 0 1 3000",
               decode_rip, out_valid, icache_enable, icache_addr);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    set_rip = 1'b1; new_rip = 64'h5000;
    step();
    set_rip = 1'b0;
    give_done();
    step();
    step();
    checks++;
    if (icache_enable !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: en=%b valid=%b need 1 1", icache_enable, out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (icache_enable !== 1'b0 || out_valid !== 1'b0 || icache_addr !== 64'd0) begin
      errors++;
      $display("FAIL async_clear: en=%b valid=%b addr=%h need 0 0 0",
               icache_enable, out_valid, icache_addr);
    end
    step();
    icache_done = 1'b0;
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (icache_enable !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL async_no_request: request issued after reset without set_rip");
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_rip;
    int streak;
    bit bad;
    do_reset();
    auto_resp = 1; lat = $urandom_range(0, 3);
    exp_rip = 64'h0;
    streak = 0;
    set_rip = 1'b1; new_rip = {$urandom, $urandom};
    exp_rip = new_rip;
    step();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      checks++;
      if (decode_rip !== exp_rip) begin
        errors++;
        $display("FAIL rand_rip cyc%0d: got %h need %h", cyc, decode_rip, exp_rip);
        exp_rip = decode_rip;
      end
      if (out_valid === 1'b1) begin
        bad = 0;
        for (int i = 0; i < 15; i++) if (dbyte(i) !== memb(exp_rip + 64'(i))) bad = 1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL rand_window cyc%0d: rip=%h bytes=%h", cyc, exp_rip, decode_bytes);
        end
        streak = 0;
      end else begin
        streak++;
      end
      if (icache_enable === 1'b1) begin
        checks++;
        if (icache_addr[5:0] !== 6'd0) begin
          errors++;
          $display("FAIL rand_align cyc%0d: addr=%h need low bits 0", cyc, icache_addr);
        end
      end
      if (streak > 40) begin
        checks++;
        errors++;
        $display("FAIL rand_progress cyc%0d: out_valid low for %0d cycles, need <= 40", cyc, streak);
        streak = 0;
      end
      set_rip = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        new_rip = {$urandom, $urandom};
      else
        new_rip = exp_rip + 64'($urandom_range(0, 200)) - 64'd100;
      out_taken = ($urandom_range(0, 3) != 0);
      bytes_consumed = 8'($urandom_range(0, 15));
      if (set_rip) begin
        exp_rip = new_rip;
        streak = 0;
      end else if (out_valid && out_taken) begin
        exp_rip = exp_rip + 64'(bytes_consumed);
      end
      step();
    end
    set_rip = 1'b0; out_taken = 1'b0; bytes_consumed = '0; auto_resp = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_start();
    test_line_straddle();
    test_streaming();
    test_redirect_busy();
    test_redirect_and_consume();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
